// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame size, sample width, complex sample type and index helpers.
package fft_pkg;

  localparam int N    = 256;
  localparam int LOGN = 8;
  localparam int DW   = 16;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef enum logic {WR_IDLE, WR_FILL} wr_state_t;
  typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] idx);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = idx[LOGN-1-i];
    return r;
  endfunction

  // Divide by N with round-half-up; one extra bit keeps d + N/2 from wrapping.
  function automatic logic signed [DW-1:0] ifft_round(input logic signed [DW-1:0] x);
    logic signed [DW:0] t;
    t = (DW+1)'(x) + (DW+1)'(2 ** (LOGN-1));
    return DW'(t >>> LOGN);
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store, address {bank, index}: one write port, one registered read port.
module fft_pingpong_ram
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          wr_en,
  input  logic [LOGN:0] wr_addr,
  input  cplx_t         wr_data,
  input  logic          rd_en,
  input  logic [LOGN:0] rd_addr,
  output cplx_t         rd_data
);

  cplx_t mem [2*N];

  // NOTE: the array and its read register carry no reset so they map onto block RAM;
  // bank full flags upstream decide whether stored contents mean anything.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_out_reorder.sv
// Bit-reversed to natural-order frame reorder with ping-pong banks and a gapless output stream.
// Define FFT_OUT_IFFT_SCALE_EN to scale inverse-transform frames by 1/N on the way out.
module fft_out_reorder
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic                 sop_in,
  input  logic                 inv_in,
  input  logic signed [DW-1:0] d_re,
  input  logic signed [DW-1:0] d_im,
  output logic                 valid_out,
  output logic                 sop_out,
  output logic                 eop_out,
  output logic signed [DW-1:0] y_re,
  output logic signed [DW-1:0] y_im
);

  wr_state_t       wr_state, wr_state_n;
  logic [LOGN-1:0] wr_cnt, wr_cnt_n, wr_idx;
  logic            wr_bank, wr_en, frame_done;

  rd_state_t       rd_state, rd_state_n;
  logic [LOGN-1:0] rd_cnt, rd_cnt_n, rd_idx;
  logic            rd_bank, rd_bank_n, rd_issue, rd_release;

  logic [1:0]      full;
  logic            s1_valid, s1_sop, s1_eop;
  cplx_t           wr_data, rd_data, y_next;

  assign wr_data = '{re: d_re, im: d_im};

  // Writer: a sop always restarts at sample 0 of the current bank, discarding any partial frame.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    wr_state_n = wr_state;
    wr_cnt_n   = wr_cnt;
    wr_en      = 1'b0;
    wr_idx     = '0;
    frame_done = 1'b0;
    if (valid_in) begin
      if (sop_in) begin
        wr_en      = 1'b1;
        wr_cnt_n   = LOGN'(1);
        wr_state_n = WR_FILL;
      end else if (wr_state == WR_FILL) begin
        wr_en    = 1'b1;
        wr_idx   = bitrev(wr_cnt);
        wr_cnt_n = wr_cnt + 1'b1;
        if (wr_cnt == LOGN'(N-1)) begin
          frame_done = 1'b1;
          wr_state_n = WR_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_IDLE;
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
    end else begin
      wr_state <= wr_state_n;
      wr_cnt   <= wr_cnt_n;
      if (frame_done) wr_bank <= ~wr_bank;
    end
  end

  // Reader: address 0 goes out in the same cycle the full bank is noticed, so a frame
  // appears two edges after its last sample and consecutive frames need no idle cycle.
  always_comb begin
    rd_state_n = rd_state;
    rd_cnt_n   = rd_cnt;
    rd_bank_n  = rd_bank;
    rd_issue   = 1'b0;
    rd_idx     = rd_cnt;
    rd_release = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (full[rd_bank]) begin
          rd_issue   = 1'b1;
          rd_idx     = '0;
          rd_cnt_n   = LOGN'(1);
          rd_state_n = RD_READ;
        end
      end
      RD_READ: begin
        rd_issue = 1'b1;
        rd_cnt_n = rd_cnt + 1'b1;
        if (rd_cnt == LOGN'(N-1)) begin
          rd_release = 1'b1;
          rd_bank_n  = ~rd_bank;
          if (!full[~rd_bank]) rd_state_n = RD_IDLE;
        end
      end
      default: rd_state_n = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
    end else begin
      rd_state <= rd_state_n;
      rd_cnt   <= rd_cnt_n;
      rd_bank  <= rd_bank_n;
    end
  end

  // Release and fill always concern different banks in legal traffic; fill wins if they ever collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (rd_release) full[rd_bank] <= 1'b0;
      if (frame_done) full[wr_bank] <= 1'b1;
    end
  end

  fft_pingpong_ram u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_idx}),
    .wr_data (wr_data),
    .rd_en   (rd_issue),
    .rd_addr ({rd_bank, rd_idx}),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
    end else begin
      s1_valid <= rd_issue;
      s1_sop   <= rd_issue && (rd_idx == '0);
      s1_eop   <= rd_issue && (rd_idx == LOGN'(N-1));
    end
  end

`ifdef FFT_OUT_IFFT_SCALE_EN
  logic       inv_cur, s1_inv;
  logic [1:0] inv_bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_cur  <= 1'b0;
      inv_bank <= '0;
      s1_inv   <= 1'b0;
    end else begin
      if (valid_in && sop_in) inv_cur <= inv_in;
      if (frame_done) inv_bank[wr_bank] <= inv_cur;
      s1_inv <= inv_bank[rd_bank];
    end
  end

  assign y_next = s1_inv ? '{re: ifft_round(rd_data.re), im: ifft_round(rd_data.im)} : rd_data;
`else
  logic unused_inv;
  assign unused_inv = inv_in;
  assign y_next     = rd_data;
`endif

  // Data registers only load with valid samples so y holds its last value between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
      y_re      <= '0;
      y_im      <= '0;
    end else begin
      valid_out <= s1_valid;
      sop_out   <= s1_sop;
      eop_out   <= s1_eop;
      if (s1_valid) begin
        y_re <= y_next.re;
        y_im <= y_next.im;
      end
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Randomized bench for fft_out_reorder against a frame-level reference model.
`timescale 1ns/1ps
module tb_fft_out_reorder;

  localparam int NB = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              valid_in = 1'b0, sop_in = 1'b0, inv_in = 1'b0;
  logic signed [15:0] d_re = '0, d_im = '0;
  logic              valid_out, sop_out, eop_out;
  logic signed [15:0] y_re, y_im;

  fft_out_reorder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .sop_in    (sop_in),
    .inv_in    (inv_in),
    .d_re      (d_re),
    .d_im      (d_im),
    .valid_out (valid_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
    .y_re      (y_re),
    .y_im      (y_im)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit sop;
    bit eop;
    int re;
    int im;
  } obs_t;

  obs_t cap[$];
  obs_t expq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always @(negedge clk)
    if (valid_out === 1'b1)
      cap.push_back('{cyc, sop_out, eop_out, int'(y_re), int'(y_im)});

  // ---------------- reference model ----------------
  int part_re[NB];
  int part_im[NB];
  int part_cnt = -1;
  bit part_inv = 1'b0;

  function automatic int rev8(input int x);
    int r = 0;
    for (int b = 0; b < 8; b++) if (((x >> b) & 1) == 1) r += 1 << (7 - b);
    return r;
  endfunction

  function automatic int ref_scale(input int x);
    int v = x + 128;
    if (v >= 0) return v / 256;
    return -((-v + 255) / 256);
  endfunction

  function automatic int rnd16();
    logic signed [15:0] v = 16'($urandom);
    return int'(v);
  endfunction

  // Bin k of a completed frame is the sample that arrived at position rev8(k);
  // the frame leaves 2 edges after its last sample, one bin per cycle.
  task automatic model_sample(input bit s, input bit inv, input int re, input int im);
    if (s) begin
      part_cnt = 0;
      part_inv = inv;
    end
    if (part_cnt < 0) return;
    part_re[part_cnt] = re;
    part_im[part_cnt] = im;
    part_cnt++;
    if (part_cnt == NB) begin
      for (int k = 0; k < NB; k++) begin
        obs_t e;
        e.cyc = cyc + 1 + 2 + k;
        e.sop = (k == 0);
        e.eop = (k == NB - 1);
        e.re  = part_re[rev8(k)];
        e.im  = part_im[rev8(k)];
`ifdef FFT_OUT_IFFT_SCALE_EN
        if (part_inv) begin
          e.re = ref_scale(e.re);
          e.im = ref_scale(e.im);
        end
`endif
        expq.push_back(e);
      end
      part_cnt = -1;
    end
  endtask

  task automatic drive(input bit v, input bit s, input bit inv, input int re, input int im);
    @(negedge clk);
    valid_in = v;
    sop_in   = s;
    inv_in   = inv;
    d_re     = 16'(re);
    d_im     = 16'(im);
    if (v) model_sample(s, inv, re, im);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, rnd16(), rnd16());
  endtask

  task automatic fresh();
    idle(4);
    cap.delete();
    expq.delete();
  endtask

  task automatic wait_drain(output bit timed_out);
    int budget = 4000;
    while (cap.size() < expq.size() && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    timed_out = (budget == 0);
    idle(20);
  endtask

  function automatic int stream_errs(output int first_bad);
    int bad = 0;
    first_bad = 0;
    for (int i = 0; i < cap.size() && i < expq.size(); i++)
      if (cap[i].cyc != expq[i].cyc || cap[i].sop != expq[i].sop || cap[i].eop != expq[i].eop ||
          cap[i].re != expq[i].re || cap[i].im != expq[i].im) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    return bad;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("cyc=%0d sop=%0d eop=%0d re=%0d im=%0d", o.cyc, o.sop, o.eop, o.re, o.im);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad = 0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (20) begin
      @(negedge clk);
      valid_in = 1'($urandom);
      sop_in   = 1'($urandom);
      inv_in   = 1'($urandom);
      d_re     = 16'($urandom);
      d_im     = 16'($urandom);
      #1;
      if (valid_out !== 1'b0 || sop_out !== 1'b0 || eop_out !== 1'b0 || y_re !== 16'sd0 || y_im !== 16'sd0)
        bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_errors++;
      $display("FAIL reset_outputs: %0d cycles with nonzero outputs, need 0", bad);
    end
    @(negedge clk);
    valid_in = 1'b0;
    sop_in   = 1'b0;
    rst_n    = 1'b1;
    cap.delete();
    expq.delete();
    part_cnt = -1;
    repeat (600) begin
      @(negedge clk);
      valid_in = 1'($urandom);
      sop_in   = 1'b0;
      d_re     = 16'($urandom);
      d_im     = 16'($urandom);
    end
    idle(4);
    n_checks++;
    if (cap.size() !== 0) begin
      n_errors++;
      $display("FAIL reset_no_sop_quiet: got %0d outputs, need 0", cap.size());
    end
  endtask

  task automatic test_single_frame();
    bit to;
    int fb, bad, got;
    fresh();
    for (int j = 0; j < NB; j++) drive(1'b1, j == 0, 1'b0, j, -j);
    idle(1);
    wait_drain(to);
    n_checks++;
    if (to || cap.size() !== NB) begin
      n_errors++;
      $display("FAIL single_count: got %0d outputs, need %0d", cap.size(), NB);
    end
    bad = stream_errs(fb);
    n_checks++;
    if (bad !== 0) begin
      n_errors++;
      $display("FAIL single_stream: %0d bad, #%0d got %s need %s", bad, fb, fmt(cap[fb]), fmt(expq[fb]));
    end
    got = (cap.size() > 1) ? cap[1].re : -99999;
    n_checks++;
    if (got !== 128) begin n_errors++; $display("FAIL single_bin1: got %0d, need 128", got); end
    got = (cap.size() > 2) ? cap[2].re : -99999;
    n_checks++;
    if (got !== 64) begin n_errors++; $display("FAIL single_bin2: got %0d, need 64", got); end
    got = (cap.size() > 255) ? cap[255].re : -99999;
    n_checks++;
    if (got !== 255) begin n_errors++; $display("FAIL single_bin255: got %0d, need 255", got); end
    got = (cap.size() > 255) ? int'(cap[255].eop) : -1;
    n_checks++;
    if (got !== 1) begin n_errors++; $display("FAIL single_eop255: got %0d, need 1", got); end
  endtask

  task automatic test_back_to_back();
    bit to, inv;
    int fb, bad, span;
    fresh();
    for (int f = 0; f < 3; f++) begin
      inv = 1'($urandom);
      for (int j = 0; j < NB; j++) drive(1'b1, j == 0, inv, rnd16(), rnd16());
    end
    idle(1);
    wait_drain(to);
    n_checks++;
    if (to || cap.size() !== 3 * NB) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d outputs, need %0d", cap.size(), 3 * NB);
    end
    span = (cap.size() == 3 * NB) ? cap[3*NB-1].cyc - cap[0].cyc : -1;
    n_checks++;
    if (span !== 3 * NB - 1) begin
      n_errors++;
      $display("FAIL b2b_contiguous: got span %0d, need %0d", span, 3 * NB - 1);
    end
    bad = stream_errs(fb);
    n_checks++;
    if (bad !== 0) begin
      n_errors++;
      $display("FAIL b2b_stream: %0d bad, #%0d got %s need %s", bad, fb, fmt(cap[fb]), fmt(expq[fb]));
    end
  endtask

  task automatic test_restart();
    bit to;
    int fb, bad;
    fresh();
    for (int j = 0; j < 100; j++) drive(1'b1, j == 0, 1'b0, rnd16(), rnd16());
    for (int j = 0; j < NB; j++) drive(1'b1, j == 0, 1'b0, rnd16(), rnd16());
    idle(1);
    wait_drain(to);
    n_checks++;
    if (to || cap.size() !== NB) begin
      n_errors++;
      $display("FAIL restart_count: got %0d outputs, need %0d", cap.size(), NB);
    end
    bad = stream_errs(fb);
    n_checks++;
    if (bad !== 0) begin
      n_errors++;
      $display("FAIL restart_stream: %0d bad, #%0d got %s need %s", bad, fb, fmt(cap[fb]), fmt(expq[fb]));
    end
  endtask

  task automatic test_gapped();
    bit to;
    int fb, bad;
    fresh();
    for (int j = 0; j < NB; j++) begin
      drive(1'b1, j == 0, 1'b0, rnd16(), rnd16());
      idle(2);
    end
    wait_drain(to);
    n_checks++;
    if (to || cap.size() !== NB) begin
      n_errors++;
      $display("FAIL gapped_count: got %0d outputs, need %0d", cap.size(), NB);
    end
    bad = stream_errs(fb);
    n_checks++;
    if (bad !== 0) begin
      n_errors++;
      $display("FAIL gapped_stream: %0d bad, #%0d got %s need %s", bad, fb, fmt(cap[fb]), fmt(expq[fb]));
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    int fb, bad, target, budget, need50;
    fresh();
    for (int j = 0; j < NB; j++) drive(1'b1, j == 0, 1'b0, rnd16(), rnd16());
    target = expq[0].cyc + 50;
    need50 = expq[50].re;
    for (int j = 0; j < 30; j++) drive(1'b1, j == 0, 1'b0, rnd16(), rnd16());
    idle(1);
    budget = 1000;
    while (cyc < target && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    n_checks++;
    if (budget == 0 || valid_out !== 1'b1 || int'(y_re) !== need50) begin
      n_errors++;
      $display("FAIL midrst_bin50: got valid=%0b re=%0d, need valid=1 re=%0d", valid_out, y_re, need50);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (valid_out !== 1'b0 || sop_out !== 1'b0 || eop_out !== 1'b0 || y_re !== 16'sd0 || y_im !== 16'sd0) begin
      n_errors++;
      $display("FAIL midrst_async: got valid=%0b sop=%0b eop=%0b re=%0d im=%0d, need all 0",
               valid_out, sop_out, eop_out, y_re, y_im);
    end
    part_cnt = -1;
    idle(3);
    rst_n = 1'b1;
    cap.delete();
    expq.delete();
    for (int j = 0; j < 240; j++) drive(1'b1, 1'b0, 1'b0, rnd16(), rnd16());
    idle(600);
    n_checks++;
    if (cap.size() !== 0) begin
      n_errors++;
      $display("FAIL midrst_quiet: got %0d outputs, need 0", cap.size());
    end
    for (int j = 0; j < NB; j++) drive(1'b1, j == 0, 1'b0, rnd16(), rnd16());
    idle(1);
    wait_drain(to);
    bad = stream_errs(fb);
    n_checks++;
    if (to || cap.size() !== NB || bad !== 0) begin
      n_errors++;
      $display("FAIL midrst_recover: got %0d outputs %0d bad, need %0d outputs 0 bad", cap.size(), bad, NB);
    end
  endtask

  task automatic test_scale();
    bit to;
    int fb, bad, got0, got128, need0, need128;
    fresh();
    for (int j = 0; j < NB; j++) begin
      int v = (j == 0) ? 32767 : (j == 1) ? -300 : rnd16();
      drive(1'b1, j == 0, 1'b1, v, rnd16());
    end
    idle(1);
    wait_drain(to);
`ifdef FFT_OUT_IFFT_SCALE_EN
    need0   = 128;
    need128 = -1;
`else
    need0   = 32767;
    need128 = -300;
`endif
    got0   = (cap.size() > 0) ? cap[0].re : -99999;
    got128 = (cap.size() > 128) ? cap[128].re : -99999;
    n_checks++;
    if (got0 !== need0) begin n_errors++; $display("FAIL scale_max: got %0d, need %0d", got0, need0); end
    n_checks++;
    if (got128 !== need128) begin n_errors++; $display("FAIL scale_neg: got %0d, need %0d", got128, need128); end
    bad = stream_errs(fb);
    n_checks++;
    if (to || cap.size() !== NB || bad !== 0) begin
      n_errors++;
      $display("FAIL scale_stream: got %0d outputs %0d bad, need %0d outputs 0 bad", cap.size(), bad, NB);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_restart();
    test_gapped();
    test_mid_reset();
    test_scale();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
Output-side companion of fft_256. It consumes the FFT core's result stream, which arrives in bit-reversed index order, and emits the same frame in natural order (bin 0..N-1) as a gapless valid/sop/eop stream. It uses two N-entry ping-pong banks so that one frame can be written while the previous frame is read.

Parameters:
N, 256, points per frame (power of 2)
LOGN, 8, log2(N); address/counter width
DW, 16, signed width of each real/imag component

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  input sample strobe
sop_in  in  1  first sample of a frame; qualified by valid_in
inv_in  in  1  frame is an inverse transform; sampled with sop_in
d_re  in  DW  signed real part, bit-reversed order
d_im  in  DW  signed imag part, bit-reversed order
valid_out  out  1  output sample valid
sop_out  out  1  bin 0 of a frame
eop_out  out  1  bin N-1 of a frame
y_re  out  DW  signed real part, natural order
y_im  out  DW  signed imag part, natural order

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). Reset clears all state.
- Reset values: valid_out, sop_out and eop_out are 0; y_re and y_im are 0; both banks are empty; write and read counters are 0; writer is in IDLE.
- Writer FSM, IDLE -> FILL:
  - In IDLE, valid_in without sop_in is ignored.
  - valid_in with sop_in writes sample 0 and enters FILL with wr_cnt=1.
  - In FILL, each valid_in stores d at address bitrev(wr_cnt) of the current write bank, then increments wr_cnt.
  - valid_in with sop_in in FILL discards the partial frame. That sample becomes sample 0 of a new frame in the same bank.
  - On the write of sample N-1, the bank's full flag is set and inv is latched per bank. The write bank toggles and the FSM returns to IDLE.
- No backpressure. Input rate is at most 1 sample/cycle and output rate is exactly 1 sample/cycle, so a bank is always released before it is needed again.
- Reader FSM, IDLE -> READ:
  - In IDLE, if the non-current bank is full, the reader enters READ on the next edge.
  - In READ, it issues sequential addresses rd_cnt = 0..N-1, one per cycle.
  - RAM read is synchronous and outputs are registered.
  - When address N-1 is issued, the bank's full flag clears. If the other bank is already full, the reader continues directly with its address 0, with no gap.
- Simultaneous events: a full-flag release and a new write into the same bank on one edge is legal.
- Latency: sop_out rises exactly 2 cycles after the edge that samples input N-1. A frame's valid_out is then high for N consecutive cycles.
- Markers: sop_out is high with bin 0 only; eop_out is high with bin N-1 only.
- Outputs when valid_out=0: y_re and y_im hold their last value.
- Reset mid-operation: all outputs drop to 0 asynchronously and both partial frames are lost. After release, the block waits for a new sop_in.

Optional Feature:
FFT_OUT_IFFT_SCALE_EN
- Defined: for frames with latched inv=1, y = (d + 2^(LOGN-1)) >>> LOGN on each component (round half up, arithmetic shift). No saturation is needed. Frames with inv=0 pass unscaled.
- Undefined: inv_in is ignored and data passes unmodified.

Decomposition:
- Package fft_pkg holds N, LOGN, DW, a signed complex-sample typedef and the bitrev function (also used by fft_256's input reorder).
- One sub-module, fft_pingpong_ram: 2N x 2*DW, one write port and one synchronous read port. Its address is {bank, index}.

Test Plan:
1. Reset: hold rst_n=0 with random inputs -> all outputs are 0; no valid_out for 600 cycles after release with no sop_in.
2. Single frame: d_re=j, d_im=-j at arrival j -> bin k gives y_re=bitrev(k) (bin1=128, bin2=64, bin255=255); sop_out 2 cycles after input 255; eop_out on bin 255.
3. Back-to-back: 3 frames, valid_in continuously high -> valid_out high for 768 consecutive cycles; sop_out every 256 cycles; data correct.
4. Restart: sop_in at wr_cnt=100, then a full frame -> exactly one output frame, carrying the second frame's data.
5. Gapped input: valid_in every 3rd cycle -> output is one contiguous 256-cycle burst, 2 cycles after the last sample.
6. Mid-read reset: rst_n low at bin 50 -> outputs 0 immediately; no output after release until a new full frame. With the macro defined and inv=1: d_re=32767 gives 128; d_re=-300 gives -1.
